// File: rtl/cmp3_arbiter_pkg.sv
// Shared definitions for the round-robin 3-bit comparator arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cmp3_arbiter_pkg;

  // Operand width of the shared comparator.
  localparam int OPW = 3;

  // Arbiter FSM: IDLE picks a winner, EVAL registers its compare result.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EVAL = 1'b1
  } state_t;

  // Result bundle, ordered {L,E,G}.
  typedef struct packed {
    logic l;
    logic e;
    logic g;
  } leg_t;

endpackage

// File: rtl/cmp3_arbiter_core.sv
// Combinational 3-bit unsigned magnitude comparator (gate-level form).
// Latency: 0 cycles, purely combinational.
// Backpressure: none; outputs follow the inputs.
module cmp3_core
  import cmp3_arbiter_pkg::*;
(
  input  logic [OPW-1:0] a,
  input  logic [OPW-1:0] b,
  output logic           L,
  output logic           E,
  output logic           G
);

  // Per-bit equality terms, shared by all three outputs.
  logic [OPW-1:0] eq;

  assign eq = ~(a ^ b);

  // The most significant differing bit decides; lower bits only count when
  // every bit above them matches.
  assign G = (a[2] & ~b[2])
           | (eq[2] & a[1] & ~b[1])
           | (eq[2] & eq[1] & a[0] & ~b[0]);

  assign L = (~a[2] & b[2])
           | (eq[2] & ~a[1] & b[1])
           | (eq[2] & eq[1] & ~a[0] & b[0]);

  assign E = &eq;

endmodule

// File: rtl/cmp3_arbiter.sv
// Round-robin arbiter sharing one registered 3-bit comparator among N requesters.
// Latency: grant one edge after an eligible request, done/result one edge after grant.
// Backpressure: one compare in flight; requests are not sampled during EVAL.
module cmp3_arbiter
  import cmp3_arbiter_pkg::*;
#(
  parameter  int N   = 4,
  localparam int IDW = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  input  logic [N-1:0]     req_mask,
  input  logic [OPW*N-1:0] a_in,
  input  logic [OPW*N-1:0] b_in,
  output logic [N-1:0]     gnt,
  output logic             busy,
  output logic             done,
  output logic [IDW-1:0]   res_id,
  output logic             L,
  output logic             E,
  output logic             G
);

  localparam logic [IDW:0]   NW   = (IDW+1)'(N);
  localparam logic [IDW-1:0] LAST = IDW'(N-1);

  state_t         state, state_nxt;
  logic [IDW-1:0] rr_ptr, rr_nxt;
  logic [IDW-1:0] win_r, win_nxt;
  logic [OPW-1:0] a_r, a_nxt;
  logic [OPW-1:0] b_r, b_nxt;
  logic [N-1:0]   gnt_nxt;
  logic           busy_nxt;
  logic           done_nxt;
  logic [IDW-1:0] res_id_nxt;
  leg_t           res_r, res_nxt;

  logic [OPW-1:0] a_arr [N];
  logic [OPW-1:0] b_arr [N];
  logic [IDW:0]   pick;
  logic           cmp_l, cmp_e, cmp_g;

  // First eligible requester at or above ptr, wrapping; MSB flags "found".
  function automatic logic [IDW:0] rr_pick(input logic [N-1:0]   elig,
                                           input logic [IDW-1:0] ptr);
    logic [IDW:0]   idx;
    logic           found;
    logic [IDW-1:0] sel;
    found = 1'b0;
    sel   = '0;
    for (int k = 0; k < N; k++) begin
      idx = {1'b0, ptr} + (IDW+1)'(k);
      if (idx >= NW) idx = idx - NW;
      if (!found && elig[idx[IDW-1:0]]) begin
        found = 1'b1;
        sel   = idx[IDW-1:0];
      end
    end
    return {found, sel};
  endfunction

  // Unpack the flat operand buses into per-requester lanes.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      a_arr[i] = a_in[OPW*i +: OPW];
      b_arr[i] = b_in[OPW*i +: OPW];
    end
  end

  assign pick = rr_pick(req & req_mask, rr_ptr);

  // The single shared comparator always looks at the captured operands.
  cmp3_core u_core (
    .a (a_r),
    .b (b_r),
    .L (cmp_l),
    .E (cmp_e),
    .G (cmp_g)
  );

  assign L = res_r.l;
  assign E = res_r.e;
  assign G = res_r.g;

  // Next-state and next-output logic; results and pointer hold unless updated.
  always_comb begin
    state_nxt  = state;
    rr_nxt     = rr_ptr;
    win_nxt    = win_r;
    a_nxt      = a_r;
    b_nxt      = b_r;
    gnt_nxt    = '0;
    busy_nxt   = 1'b0;
    done_nxt   = 1'b0;
    res_id_nxt = res_id;
    res_nxt    = res_r;
    case (state)
      ST_IDLE: begin
        if (pick[IDW]) begin
          a_nxt     = a_arr[pick[IDW-1:0]];
          b_nxt     = b_arr[pick[IDW-1:0]];
          win_nxt   = pick[IDW-1:0];
          gnt_nxt   = {{(N-1){1'b0}}, 1'b1} << pick[IDW-1:0];
          busy_nxt  = 1'b1;
          state_nxt = ST_EVAL;
        end
      end
      ST_EVAL: begin
        done_nxt   = 1'b1;
        res_nxt    = '{l: cmp_l, e: cmp_e, g: cmp_g};
        res_id_nxt = win_r;
        rr_nxt     = (win_r == LAST) ? '0 : win_r + 1'b1;
        state_nxt  = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State and output registers; reset drops any in-flight compare.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      rr_ptr <= '0;
      win_r  <= '0;
      a_r    <= '0;
      b_r    <= '0;
      gnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      res_id <= '0;
      res_r  <= '0;
    end else begin
      state  <= state_nxt;
      rr_ptr <= rr_nxt;
      win_r  <= win_nxt;
      a_r    <= a_nxt;
      b_r    <= b_nxt;
      gnt    <= gnt_nxt;
      busy   <= busy_nxt;
      done   <= done_nxt;
      res_id <= res_id_nxt;
      res_r  <= res_nxt;
    end
  end

endmodule
